// File: rtl/uart_rx_frame_if.sv
// Receiver-side signal bundle for the UART receive framer.
// The master modport is the framer itself; the slave modport is the surroundings:
// the line, the baud controller and the parallel-data consumer.
interface uart_rx_frame_if #(
    parameter int DATA_BITS = 8
);
    logic                 Rx_EN;
    logic                 RxD;
    logic                 sample_ENABLE;
    logic [DATA_BITS-1:0] Rx_DATA;
    logic                 Rx_VALID;
    logic                 Rx_PERROR;
    logic                 Rx_FERROR;

    modport master (
        input  Rx_EN, RxD, sample_ENABLE,
        output Rx_DATA, Rx_VALID, Rx_PERROR, Rx_FERROR
    );

    modport slave (
        output Rx_EN, RxD, sample_ENABLE,
        input  Rx_DATA, Rx_VALID, Rx_PERROR, Rx_FERROR
    );
endinterface

// File: rtl/uart_rx_frame.sv
// UART receive framer.
// - Synchronises RxD with two flops.
// - Finds the start bit and takes a three-sample majority vote at ticks 7/8/9 of each
//   bit, using the 16x oversampling tick.
// - Releases the frame at mid stop bit, so the receiver can resync to back-to-back frames.
module uart_rx_frame #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic              clk,
    input  logic              reset,
    uart_rx_frame_if.master   bus
);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [3:0] TICK_V1   = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0] TICK_V2   = 4'(OVERSAMPLE / 2);
    localparam logic [3:0] TICK_V3   = 4'(OVERSAMPLE / 2 + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic                 r_sync1, r_sync2;
    logic [3:0]           r_tick_cnt;
    logic [BW-1:0]        r_bit_cnt;
    logic                 r_s7, r_s8, r_vote;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_perr;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid, r_perror, r_ferror;

    logic w_tick, w_vote, w_bit_end, w_last_bit, w_stop_done, w_perr_calc;

    // Decode the per-tick events that drive both the FSM and the datapath.
    always_comb begin
        w_tick      = bus.sample_ENABLE;
        w_vote      = (r_s7 & r_s8) | (r_s7 & r_sync2) | (r_s8 & r_sync2);
        w_bit_end   = w_tick && (r_tick_cnt == TICK_LAST);
        w_last_bit  = (r_bit_cnt == BW'(DATA_BITS - 1));
        w_stop_done = (r_state == S_STOP) && w_tick && (r_tick_cnt == TICK_V3);
        w_perr_calc = (^r_shift) ^ r_vote ^ 1'(PARITY_ODD);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_next;
    end

    // Next-state logic; a low enable overrides any pending tick.
    always_comb begin
        w_state_next = r_state;
        if (!bus.Rx_EN) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:   if (w_tick && !r_sync2) w_state_next = S_START;
                S_START:  if (w_bit_end) w_state_next = r_vote ? S_IDLE : S_DATA;
                S_DATA:   if (w_bit_end && w_last_bit)
                              w_state_next = (PARITY_EN != 0) ? S_PARITY : S_STOP;
                S_PARITY: if (w_bit_end) w_state_next = S_STOP;
                S_STOP:   if (w_stop_done) w_state_next = w_vote ? S_IDLE : S_BREAK;
                S_BREAK:  if (w_tick && r_sync2) w_state_next = S_IDLE;
                default:  w_state_next = S_IDLE;
            endcase
        end
    end

    // Datapath: synchroniser, tick/bit counters, vote samples, shifter and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1    <= 1'b1;
            r_sync2    <= 1'b1;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_s7       <= 1'b0;
            r_s8       <= 1'b0;
            r_vote     <= 1'b0;
            r_shift    <= '0;
            r_perr     <= 1'b0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_perror   <= 1'b0;
            r_ferror   <= 1'b0;
        end else begin
            r_sync1 <= bus.RxD;
            r_sync2 <= r_sync1;
            r_valid <= 1'b0;
            if (!bus.Rx_EN) begin
                r_tick_cnt <= '0;
                r_bit_cnt  <= '0;
                r_s7       <= 1'b0;
                r_s8       <= 1'b0;
                r_vote     <= 1'b0;
            end else if (w_tick) begin
                // Tick counter: the detect tick is tick 0 of the start bit.
                // The count wraps at every bit boundary; stop ends early at mid-bit.
                case (r_state)
                    S_IDLE:  r_tick_cnt <= r_sync2 ? 4'd0 : 4'd1;
                    S_BREAK: r_tick_cnt <= '0;
                    S_STOP:  r_tick_cnt <= (r_tick_cnt == TICK_V3) ? 4'd0 : r_tick_cnt + 4'd1;
                    default: r_tick_cnt <= r_tick_cnt + 4'd1;
                endcase
                if (r_tick_cnt == TICK_V1) r_s7   <= r_sync2;
                if (r_tick_cnt == TICK_V2) r_s8   <= r_sync2;
                if (r_tick_cnt == TICK_V3) r_vote <= w_vote;
                if (w_bit_end) begin
                    case (r_state)
                        S_START:  r_bit_cnt <= '0;
                        S_DATA: begin
                            r_shift   <= {r_vote, r_shift[DATA_BITS-1:1]};
                            r_bit_cnt <= w_last_bit ? '0 : r_bit_cnt + 1'b1;
                        end
                        S_PARITY: r_perr <= w_perr_calc;
                        default: ;
                    endcase
                end
                if (w_stop_done) begin
                    r_data   <= r_shift;
                    r_perror <= (PARITY_EN != 0) ? r_perr : 1'b0;
                    r_ferror <= ~w_vote;
                    r_valid  <= w_vote && !((PARITY_EN != 0) && r_perr);
                end
            end
        end
    end

    assign bus.Rx_DATA   = r_data;
    assign bus.Rx_VALID  = r_valid;
    assign bus.Rx_PERROR = r_perror;
    assign bus.Rx_FERROR = r_ferror;
endmodule
